// File: rtl/hazard_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the hazard scoreboard slice.
//   entry_t     : one in-flight writer {valid, rd, regwrite, is_load}. rd is
//                 stored at RW_MAX bits so one struct serves every NREG choice;
//                 narrower register addresses are zero-extended into it.
//   FWD_REGFILE : forward-select code meaning "use the register file value".
//   DEPTH_MIN   : smallest legal number of tracked stages.
//   sel_width() : address/select width derivation, never narrower than 1 bit.
// ---------------------------------------------------------------------------
package hazard_pkg;

   localparam int FWD_REGFILE = 0;
   localparam int DEPTH_MIN   = 2;
   localparam int RW_MAX      = 16;

   typedef struct packed {
      logic              valid;
      logic [RW_MAX-1:0] rd;
      logic              regwrite;
      logic              is_load;
   } entry_t;

   // ceil(log2(n)) clamped to at least one bit so tiny configurations still get a real bus.
   function automatic int sel_width(input int n);
      int w;
      w = 1;
      while ((32'sd1 <<< w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_if
// ID-stage instruction description in, stall and EX forward selects out.
//   hold                        : global pipeline freeze.
//   id_valid / id_flush         : ID holds a real instruction / it is squashed.
//   id_rs(_used), id_rt(_used)  : the two sources and whether they are read.
//   id_rd, id_regwrite          : destination and whether it is written.
//   id_is_load                  : instruction is a load.
//   stall                       : combinational load-use stall.
//   ex_fwd_a / ex_fwd_b         : registered forward selects for EX.
// Modports: master drives the instruction (pipeline side), slave is the
// scoreboard.
// ---------------------------------------------------------------------------
interface hazard_scoreboard_if #(
   parameter int RW = 4,
   parameter int FW = 2
) ();

   logic          hold;
   logic          id_valid;
   logic          id_flush;
   logic [RW-1:0] id_rs;
   logic          id_rs_used;
   logic [RW-1:0] id_rt;
   logic          id_rt_used;
   logic [RW-1:0] id_rd;
   logic          id_regwrite;
   logic          id_is_load;
   logic          stall;
   logic [FW-1:0] ex_fwd_a;
   logic [FW-1:0] ex_fwd_b;

   modport master (
      output hold, id_valid, id_flush, id_rs, id_rs_used, id_rt, id_rt_used,
             id_rd, id_regwrite, id_is_load,
      input  stall, ex_fwd_a, ex_fwd_b
   );

   modport slave (
      input  hold, id_valid, id_flush, id_rs, id_rs_used, id_rt, id_rt_used,
             id_rd, id_regwrite, id_is_load,
      output stall, ex_fwd_a, ex_fwd_b
   );

endinterface

// File: rtl/hazard_scoreboard_match.sv
// ---------------------------------------------------------------------------
// hazard_match
// Combinational comparison of one ID source against the forwardable in-flight
// writers (entries 0..DEPTH-2; the WB entry is covered by regfile
// write-before-read and is never a forwarding source).
//   entries   : in : entries 0 (EX) .. DEPTH-2.
//   src       : in : source register address.
//   src_used  : in : the source is actually read.
//   any_match : out: some forwardable entry writes src.
//   fwd_sel   : out: k+1 of the youngest matching entry, FWD_REGFILE if none.
//   load_hit  : out: a load in entries 0..LOAD_READY-2 writes src (data not
//                    ready yet, consumer must stall).
// ---------------------------------------------------------------------------
module hazard_match
   import hazard_pkg::*;
#(
   parameter int DEPTH      = 3,
   parameter int LOAD_READY = 2,
   parameter int RW         = 4,
   parameter int FW         = 2,
   parameter bit R0_ZERO    = 1'b1
) (
   input  entry_t [DEPTH-2:0] entries,
   input  logic [RW-1:0]      src,
   input  logic               src_used,
   output logic               any_match,
   output logic [FW-1:0]      fwd_sel,
   output logic               load_hit
);

   logic             src_live_s;
   logic [DEPTH-2:0] hit_s;
   logic             unused_entry_bits_s;

   // A source only creates a hazard when it is read and is not the hardwired zero register.
   always_comb begin
      src_live_s = src_used & ~(R0_ZERO & (src == {RW{1'b0}}));
   end

   // Per-entry hit: live writer of the same register.
   always_comb begin
      hit_s = {(DEPTH-1){1'b0}};
      for (int k = 0; k < DEPTH - 1; k++) begin
         hit_s[k] = entries[k].valid & entries[k].regwrite & src_live_s &
                    (entries[k].rd == RW_MAX'(src));
      end
   end

   // Scan from oldest to youngest so the youngest hit overwrites older ones.
   always_comb begin
      any_match = 1'b0;
      fwd_sel   = FW'(FWD_REGFILE);
      for (int k = DEPTH - 2; k >= 0; k--) begin
         any_match = any_match | hit_s[k];
         fwd_sel   = hit_s[k] ? FW'(k + 1) : fwd_sel;
      end
   end

   // Loads whose data has not reached the first forwardable stage yet.
   always_comb begin
      load_hit = 1'b0;
      for (int k = 0; k < LOAD_READY - 1; k++) begin
         load_hit = load_hit | (hit_s[k] & entries[k].is_load);
      end
   end

   // is_load of entries past the load-ready point is deliberately ignored.
   always_comb begin
      unused_entry_bits_s = ^entries;
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Parametrised hazard/forwarding scoreboard beside the ID/EX latches. Tracks
// in-flight writers from EX to WB, raises a combinational load-use stall for
// the ID instruction and registers the EX operand forward selects.
//   clk, rst_n      : clock, asynchronous active-low reset.
//   sb (slave)      : ID instruction in; stall, ex_fwd_a, ex_fwd_b out.
//   perf_stall_cnt  : (HAZARD_SCOREBOARD_PERF_EN only) stalled, unheld cycles.
//   perf_fwd_cnt    : (HAZARD_SCOREBOARD_PERF_EN only) edges loading a nonzero
//                     forward select. Both counters saturate.
// Optional feature macro: HAZARD_SCOREBOARD_PERF_EN.
// Only entries 0..DEPTH-2 are stored: the WB entry is never read here because
// its write reaches the regfile before the ID read in the same cycle.
// ---------------------------------------------------------------------------
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NREG       = 16,
   parameter int RW         = sel_width(NREG),
   parameter int DEPTH      = 3,
   parameter int LOAD_READY = 2,
   parameter int FW         = sel_width(DEPTH),
   parameter bit R0_ZERO    = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   hazard_scoreboard_if.slave  sb
`ifdef HAZARD_SCOREBOARD_PERF_EN
   ,
   output logic [31:0]         perf_stall_cnt,
   output logic [31:0]         perf_fwd_cnt
`endif
);

   entry_t [DEPTH-2:0] entries_r;
   entry_t             entry_in_s;
   logic [FW-1:0]      fwd_a_r;
   logic [FW-1:0]      fwd_b_r;
   logic [FW-1:0]      fwd_a_next_s;
   logic [FW-1:0]      fwd_b_next_s;
   logic [FW-1:0]      sel_a_s;
   logic [FW-1:0]      sel_b_s;
   logic               match_a_s;
   logic               match_b_s;
   logic               load_hit_a_s;
   logic               load_hit_b_s;
   logic               stall_s;
   logic               accept_s;

   hazard_match #(
      .DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .RW(RW), .FW(FW), .R0_ZERO(R0_ZERO)
   ) u_match_rs (
      .entries  (entries_r),
      .src      (sb.id_rs),
      .src_used (sb.id_rs_used),
      .any_match(match_a_s),
      .fwd_sel  (sel_a_s),
      .load_hit (load_hit_a_s)
   );

   hazard_match #(
      .DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .RW(RW), .FW(FW), .R0_ZERO(R0_ZERO)
   ) u_match_rt (
      .entries  (entries_r),
      .src      (sb.id_rt),
      .src_used (sb.id_rt_used),
      .any_match(match_b_s),
      .fwd_sel  (sel_b_s),
      .load_hit (load_hit_b_s)
   );

   // Load-use stall; a flushed or empty ID slot never stalls, and hold does not mask it.
   always_comb begin
      stall_s = 1'b0;
      if (sb.id_valid && !sb.id_flush) begin
         stall_s = load_hit_a_s | load_hit_b_s;
      end else begin
         stall_s = 1'b0;
      end
   end

   // Next EX entry and selects: a bubble carries no writer and forwards nothing.
   always_comb begin
      accept_s   = sb.id_valid & ~sb.id_flush & ~stall_s;
      entry_in_s = '0;
      if (accept_s) begin
         entry_in_s.valid    = 1'b1;
         entry_in_s.rd       = RW_MAX'(sb.id_rd);
         entry_in_s.regwrite = sb.id_regwrite;
         entry_in_s.is_load  = sb.id_is_load;
      end else begin
         entry_in_s = '0;
      end
      fwd_a_next_s = (accept_s & match_a_s) ? sel_a_s : FW'(FWD_REGFILE);
      fwd_b_next_s = (accept_s & match_b_s) ? sel_b_s : FW'(FWD_REGFILE);
   end

   // Writer shift register and forward-select registers; everything freezes on hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entries_r <= '0;
         fwd_a_r   <= FW'(FWD_REGFILE);
         fwd_b_r   <= FW'(FWD_REGFILE);
      end else if (!sb.hold) begin
         entries_r[0] <= entry_in_s;
         for (int j = 1; j < DEPTH - 1; j++) begin
            entries_r[j] <= entries_r[j-1];
         end
         fwd_a_r <= fwd_a_next_s;
         fwd_b_r <= fwd_b_next_s;
      end
   end

   assign sb.stall    = stall_s;
   assign sb.ex_fwd_a = fwd_a_r;
   assign sb.ex_fwd_b = fwd_b_r;

`ifdef HAZARD_SCOREBOARD_PERF_EN
   // Saturating stall and forward event counters, frozen by hold like the rest of the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cnt <= 32'd0;
         perf_fwd_cnt   <= 32'd0;
      end else if (!sb.hold) begin
         if (stall_s && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
         if (((fwd_a_next_s != FW'(FWD_REGFILE)) || (fwd_b_next_s != FW'(FWD_REGFILE))) &&
             (perf_fwd_cnt != 32'hFFFF_FFFF)) begin
            perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
